// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, capture FSM encodings and line-format enums
package uart_pkg;

    // Default geometry of the receive path
    localparam int UART_DATA_LEN    = 8;
    localparam int UART_FIFO_DEPTH  = 16;
    localparam int UART_FIFO_ADDR_W = 4;

    // Receive-FIFO capture FSM encodings (2 bits)
    localparam logic [1:0] CAP_IDLE     = 2'd0;
    localparam logic [1:0] CAP_ACK      = 2'd1;
    localparam logic [1:0] CAP_WAIT_CLR = 2'd2;

    // Receiver parity configuration
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_e;

    // Receiver stop-bit configuration
    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } stop_mode_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and consumer-side signals of the UART receive FIFO
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_LEN = UART_DATA_LEN,
    parameter int ADDR_W   = UART_FIFO_ADDR_W
);

    logic [DATA_LEN-1:0] rx_data;
    logic                rx_ready;
    logic                rx_overwritten;
    logic                rx_parity_error;
    logic                rx_ack;
    logic                rd_en;
    logic [DATA_LEN-1:0] rd_data;
    logic                rd_perr;
    logic                empty;
    logic                full;
    logic [ADDR_W:0]     count;
    logic                overflow;
    logic                clr_overflow;

    // Receiver plus consumer side, driving the FIFO
    modport master (
        output rx_data, rx_ready, rx_overwritten, rx_parity_error, rd_en, clr_overflow,
        input  rx_ack, rd_data, rd_perr, empty, full, count, overflow
    );

    // The FIFO itself
    modport slave (
        input  rx_data, rx_ready, rx_overwritten, rx_parity_error, rd_en, clr_overflow,
        output rx_ack, rd_data, rd_perr, empty, full, count, overflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register-array storage, synchronous write, asynchronous read, no reset
module uart_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store one entry per write strobe; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - captures bytes from the UART receiver into a first-word fall-through FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_LEN = UART_DATA_LEN,
    parameter int DEPTH    = UART_FIFO_DEPTH,
    parameter int ADDR_W   = UART_FIFO_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] L_FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ack;
    logic              r_overflow;

    logic              w_capture;
    logic              w_wr;
    logic              w_rd;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic [DATA_LEN:0] w_head;

    assign w_full    = (r_count == L_FULL_COUNT);
    assign w_empty   = (r_count == '0);

    // A capture happens only on the first IDLE cycle that sees rx_ready
    assign w_capture = (r_state == CAP_IDLE) && bus.rx_ready;
    assign w_rd      = bus.rd_en && !w_empty;
    // When full, a same-cycle pop frees the slot the new byte lands in
    assign w_wr      = w_capture && (!w_full || bus.rd_en);
    assign w_ovf_set = w_capture && (bus.rx_overwritten || (w_full && !bus.rd_en));

    // Capture FSM next state: IDLE -> ACK -> WAIT_CLR until the receiver drops rx_ready
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CAP_IDLE:     if (bus.rx_ready)  w_state_nxt = CAP_ACK;
            CAP_ACK:                         w_state_nxt = CAP_WAIT_CLR;
            CAP_WAIT_CLR: if (!bus.rx_ready) w_state_nxt = CAP_IDLE;
            default:                         w_state_nxt = CAP_IDLE;
        endcase
    end

    // FSM state and the registered acknowledge, which is high exactly while in ACK
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CAP_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_capture;
        end
    end

    // Read/write pointers wrap naturally at DEPTH; occupancy tracked as an up/down counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky loss flag; a new loss in the same cycle beats a clear request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .WIDTH  (DATA_LEN + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.rx_parity_error, bus.rx_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign bus.rx_ack   = r_ack;
    assign bus.rd_data  = w_head[DATA_LEN-1:0];
    assign bus.rd_perr  = w_head[DATA_LEN];
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DL    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_LEN(DL), .ADDR_W(AW)) bus ();

    uart_rx_fifo #(.DATA_LEN(DL), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int ack_pulses = 0;
    int dbl_ack = 0;
    logic prev_ack = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       o;
        logic [7:0] exp_d;
        logic       exp_p;
        logic [4:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    // Acknowledge monitor, sampled between edges
    always begin
        @(posedge clk);
        #2;
        if (bus.rx_ack === 1'b1) ack_pulses++;
        if (bus.rx_ack === 1'b1 && prev_ack === 1'b1) dbl_ack++;
        prev_ack = bus.rx_ack;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic o, input logic rd);
        bus.rx_data         = d;
        bus.rx_parity_error = p;
        bus.rx_overwritten  = o;
        bus.rx_ready        = 1'b1;
        bus.rd_en           = rd;
        step();
        bus.rd_en = 1'b0;
        chk("ack_after_capture", bus.rx_ack, 1);
        bus.rx_ready        = 1'b0;
        bus.rx_overwritten  = 1'b0;
        bus.rx_parity_error = 1'b0;
        steps(2);
    endtask

    task automatic pop(input string name, input logic [7:0] d, input logic p);
        chk(name, bus.rd_data, d);
        chk({name, "_perr"}, bus.rd_perr, p);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic clr();
        bus.clr_overflow = 1'b1;
        step();
        bus.clr_overflow = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[5];
        int         base;
        logic [8:0] q[$];
        logic       m_ovf, exp_ack, first, cap, was_full, do_pop, do_push, ovw;
        int         hold_left, gap_left, rd_pct;

        bus.rx_data         = '0;
        bus.rx_ready        = 1'b0;
        bus.rx_overwritten  = 1'b0;
        bus.rx_parity_error = 1'b0;
        bus.rd_en           = 1'b0;
        bus.clr_overflow    = 1'b0;

        tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 5'd1, 1'b0};
        tbl[1] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 5'd1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 5'd1, 1'b1};
        tbl[4] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 5'd1, 1'b0};

        // Reset state
        steps(3);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_ack", bus.rx_ack, 0);
        rst = 1'b1;
        step();

        // Table-driven single-byte transactions
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].d, tbl[i].p, tbl[i].o, 1'b0);
            chk("tbl_count", bus.count, tbl[i].exp_cnt);
            chk("tbl_overflow", bus.overflow, tbl[i].exp_ovf);
            pop("tbl_data", tbl[i].exp_d, tbl[i].exp_p);
            clr();
            chk("tbl_empty_after", bus.empty, 1);
            chk("tbl_ovf_cleared", bus.overflow, 0);
        end

        // Pop while empty is ignored
        bus.rd_en = 1'b1;
        steps(2);
        bus.rd_en = 1'b0;
        chk("rd_empty_count", bus.count, 0);
        chk("rd_empty_empty", bus.empty, 1);
        chk("rd_empty_ovf", bus.overflow, 0);
        push(8'h77, 1'b0, 1'b0, 1'b0);
        pop("rd_empty_head", 8'h77, 1'b0);

        // Single byte, rx_ready held five cycles
        base = ack_pulses;
        bus.rx_data  = 8'hA5;
        bus.rx_ready = 1'b1;
        step();
        chk("single_empty_edge", bus.empty, 0);
        chk("single_count_edge", bus.count, 1);
        steps(4);
        bus.rx_ready = 1'b0;
        steps(2);
        chk("single_ack_pulses", ack_pulses - base, 1);
        chk("single_count", bus.count, 1);
        pop("single_data", 8'hA5, 1'b0);

        // Fill, then one byte too many
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        chk("fill_ovf", bus.overflow, 0);
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("fill_drop_ovf", bus.overflow, 1);
        chk("fill_drop_count", bus.count, 16);
        for (int i = 0; i < 16; i++) pop("fill_pop", 8'(i), 1'b0);
        chk("fill_empty", bus.empty, 1);
        chk("fill_not_full", bus.full, 0);
        clr();
        chk("fill_clr", bus.overflow, 0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) push(8'(i + 'h30), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) pop("wrap_a", 8'(i + 'h30), 1'b0);
        for (int i = 0; i < 12; i++) push(8'(i + 'h30), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) pop("wrap_b", 8'(i + 'h30), 1'b0);
        chk("wrap_count", bus.count, 0);
        chk("wrap_empty", bus.empty, 1);
        chk("wrap_ovf", bus.overflow, 0);

        // Full with a same-cycle capture and pop
        for (int i = 0; i < 16; i++) push(8'(i + 'h40), 1'b0, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0, 1'b1);
        chk("fullrw_count", bus.count, 16);
        chk("fullrw_full", bus.full, 1);
        chk("fullrw_ovf", bus.overflow, 0);
        for (int i = 1; i < 16; i++) pop("fullrw_pop", 8'(i + 'h40), 1'b0);
        pop("fullrw_last", 8'hFF, 1'b0);
        chk("fullrw_empty", bus.empty, 1);

        // Upstream loss
        push(8'h11, 1'b0, 1'b1, 1'b0);
        chk("upstream_ovf", bus.overflow, 1);
        chk("upstream_count", bus.count, 1);
        chk("upstream_data", bus.rd_data, 8'h11);
        clr();
        chk("upstream_clr", bus.overflow, 0);
        pop("upstream_pop", 8'h11, 1'b0);

        // Reset during WAIT_CLR with three entries
        push(8'h01, 1'b0, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0, 1'b0);
        bus.rx_data  = 8'h03;
        bus.rx_ready = 1'b1;
        step();
        chk("rstmid_count3", bus.count, 3);
        step();
        rst = 1'b0;
        #1;
        chk("rstmid_count", bus.count, 0);
        chk("rstmid_empty", bus.empty, 1);
        chk("rstmid_ack", bus.rx_ack, 0);
        chk("rstmid_full", bus.full, 0);
        @(negedge clk);
        steps(1);
        bus.rx_data = 8'h44;
        rst = 1'b1;
        base = ack_pulses;
        step();
        chk("rstmid_recap_count", bus.count, 1);
        chk("rstmid_recap_ack", bus.rx_ack, 1);
        steps(3);
        chk("rstmid_once", bus.count, 1);
        bus.rx_ready = 1'b0;
        steps(2);
        chk("rstmid_ack_pulses", ack_pulses - base, 1);
        pop("rstmid_data", 8'h44, 1'b0);

        // Randomized traffic against a queue model
        m_ovf = 1'b0; exp_ack = 1'b0; first = 1'b0; ovw = 1'b0;
        hold_left = 0; gap_left = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            chk("rnd_count", bus.count, q.size());
            chk("rnd_empty", bus.empty, q.size() == 0);
            chk("rnd_full", bus.full, q.size() == DEPTH);
            chk("rnd_overflow", bus.overflow, m_ovf);
            chk("rnd_ack", bus.rx_ack, exp_ack);
            if (q.size() > 0) chk("rnd_head", {bus.rd_perr, bus.rd_data}, q[0]);

            rd_pct = (cyc < 200) ? 2 : (cyc < 400) ? 60 : (cyc < 600) ? 20 : 2;
            if (hold_left == 0 && gap_left == 0) begin
                hold_left           = $urandom_range(1, 4);
                bus.rx_data         = 8'($urandom);
                bus.rx_parity_error = 1'($urandom);
                ovw                 = ($urandom % 6) == 0;
                bus.rx_overwritten  = ovw;
                first               = 1'b1;
            end
            if (hold_left > 0) begin
                bus.rx_ready = 1'b1;
                hold_left--;
                if (hold_left == 0) gap_left = $urandom_range(3, 5);
            end else begin
                bus.rx_ready = 1'b0;
                gap_left--;
            end
            bus.rd_en        = ($urandom % 100) < rd_pct;
            bus.clr_overflow = ($urandom % 16) == 0;

            cap      = bus.rx_ready && first;
            first    = 1'b0;
            was_full = (q.size() == DEPTH);
            do_pop   = bus.rd_en && (q.size() > 0);
            do_push  = cap && (!was_full || bus.rd_en);
            if (cap && (ovw || (was_full && !bus.rd_en))) m_ovf = 1'b1;
            else if (bus.clr_overflow) m_ovf = 1'b0;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({bus.rx_parity_error, bus.rx_data});
            exp_ack = cap;
            step();
        end

        chk("ack_never_back_to_back", dbl_ack, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
